// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge.
// Holds the AHB transfer-type and response encodings, the default peripheral
// address map, the error-response state type and a window-membership helper.
// Used by the AHB slave interface, its address decoder and the APB controller.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] DEF_SLV0_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_SLV1_BASE = 32'h8400_0000;
    localparam logic [31:0] DEF_SLV2_BASE = 32'h8800_0000;
    localparam logic [31:0] DEF_SLV_SIZE  = 32'h0400_0000;

    localparam int NUM_SLV = 3;

    typedef enum logic [1:0] {
        ERR_OKAY = 2'b00,
        ERR_ERR1 = 2'b01,
        ERR_ERR2 = 2'b10
    } err_state_t;

    // True when addr lies in [base, base+size). The subtraction form avoids
    // overflow of base+size for a window at the very top of the address map.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address decoder for the AHB slave interface.
// Ports:
//   haddr      in  32  AHB address-phase address
//   hsize      in  3   AHB transfer size
//   tempselx   out 3   one-hot peripheral select, 000 when unmapped
//   mapped     out 1   address falls inside one of the peripheral windows
//   misaligned out 1   address not aligned to hsize, or hsize wider than a word
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
    parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
    parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE,
    parameter logic [31:0] SLV_SIZE  = DEF_SLV_SIZE
) (
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    output logic [2:0]  tempselx,
    output logic        mapped,
    output logic        misaligned
);

    localparam logic [NUM_SLV-1:0][31:0] SLV_BASE = {SLV2_BASE, SLV1_BASE, SLV0_BASE};

    // Windows are disjoint, so at most one select bit can be set.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_win
            assign tempselx[gi] = in_window(haddr, SLV_BASE[gi], SLV_SIZE);
        end
    endgenerate

    assign mapped = |tempselx;

    always_comb begin
        misaligned = 1'b0;
        case (hsize)
            3'b000:  misaligned = 1'b0;
            3'b001:  misaligned = haddr[0];
            3'b010:  misaligned = |haddr[1:0];
            default: misaligned = 1'b1;   // wider than the 32-bit bus
        endcase
    end

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB-facing front stage of the AHB-to-APB bridge.
// Qualifies AHB transfers into a zero-latency 'valid', decodes the peripheral
// select, keeps 4-deep address/data/direction pipelines for the APB controller,
// and generates the two-cycle AHB ERROR response for bad accesses.
// Ports:
//   hclk, hreset                 clock, asynchronous active-high reset
//   haddr, hwdata, htrans,
//   hsize, hwrite, hreadyin      AHB master side inputs
//   valid, tempselx              combinational transfer qualifier and select
//   haddr1..4, hwdata1..4        address / write-data pipeline stages
//   hwritereg, hwritereg1..3     direction pipeline stages
//   hresp, err_stall             registered response and HREADYOUT stall
module ahb_slave_interface
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
    parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
    parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE,
    parameter logic [31:0] SLV_SIZE  = DEF_SLV_SIZE
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic        hreadyin,
    output logic        valid,
    output logic [2:0]  tempselx,
    output logic [31:0] haddr1,
    output logic [31:0] haddr2,
    output logic [31:0] haddr3,
    output logic [31:0] haddr4,
    output logic [31:0] hwdata1,
    output logic [31:0] hwdata2,
    output logic [31:0] hwdata3,
    output logic [31:0] hwdata4,
    output logic        hwritereg,
    output logic        hwritereg1,
    output logic        hwritereg2,
    output logic        hwritereg3,
    output logic [1:0]  hresp,
    output logic        err_stall
);

    logic        mapped;
    logic        misaligned;
    logic        active;
    logic        bad_xfer;

    logic [31:0] addr_pipe_reg  [1:4];
    logic [31:0] data_pipe_reg  [1:4];
    logic        write_pipe_reg [1:4];

    err_state_t  state_reg, state_next;
    logic [1:0]  hresp_reg;
    logic        err_stall_reg;

    ahb_addr_decode #(
        .SLV0_BASE (SLV0_BASE),
        .SLV1_BASE (SLV1_BASE),
        .SLV2_BASE (SLV2_BASE),
        .SLV_SIZE  (SLV_SIZE)
    ) u_decode (
        .haddr      (haddr),
        .hsize      (hsize),
        .tempselx   (tempselx),
        .mapped     (mapped),
        .misaligned (misaligned)
    );

    assign active   = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign bad_xfer = hreadyin && active && (!mapped || misaligned);
    assign valid    = hreadyin && active && mapped && !misaligned && (state_reg == ERR_OKAY);

    // Pipelines shift on every hreadyin cycle, independent of transfer validity;
    // the controller picks the stage matching the data phase it is replaying.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            addr_pipe_reg[1]  <= '0;
            data_pipe_reg[1]  <= '0;
            write_pipe_reg[1] <= 1'b0;
        end else if (hreadyin) begin
            addr_pipe_reg[1]  <= haddr;
            data_pipe_reg[1]  <= hwdata;
            write_pipe_reg[1] <= hwrite;
        end
    end

    genvar gi;
    generate
        for (gi = 2; gi <= 4; gi++) begin : g_stage
            always_ff @(posedge hclk or posedge hreset) begin
                if (hreset) begin
                    addr_pipe_reg[gi]  <= '0;
                    data_pipe_reg[gi]  <= '0;
                    write_pipe_reg[gi] <= 1'b0;
                end else if (hreadyin) begin
                    addr_pipe_reg[gi]  <= addr_pipe_reg[gi-1];
                    data_pipe_reg[gi]  <= data_pipe_reg[gi-1];
                    write_pipe_reg[gi] <= write_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign haddr1     = addr_pipe_reg[1];
    assign haddr2     = addr_pipe_reg[2];
    assign haddr3     = addr_pipe_reg[3];
    assign haddr4     = addr_pipe_reg[4];
    assign hwdata1    = data_pipe_reg[1];
    assign hwdata2    = data_pipe_reg[2];
    assign hwdata3    = data_pipe_reg[3];
    assign hwdata4    = data_pipe_reg[4];
    assign hwritereg  = write_pipe_reg[1];
    assign hwritereg1 = write_pipe_reg[2];
    assign hwritereg2 = write_pipe_reg[3];
    assign hwritereg3 = write_pipe_reg[4];

    // Error FSM. A bad address arriving during ERR1 is deliberately ignored:
    // the master must cancel its next transfer on seeing ERROR.
    always_comb begin
        state_next = ERR_OKAY;
        case (state_reg)
            ERR_OKAY: state_next = bad_xfer ? ERR_ERR1 : ERR_OKAY;
            ERR_ERR1: state_next = ERR_ERR2;
            ERR_ERR2: state_next = bad_xfer ? ERR_ERR1 : ERR_OKAY;
            default:  state_next = ERR_OKAY;
        endcase
    end

    // Response outputs are flops loaded from the next state so they change
    // exactly when the state does and carry no decode glitches.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_reg     <= ERR_OKAY;
            hresp_reg     <= HRESP_OKAY;
            err_stall_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hresp_reg     <= (state_next == ERR_OKAY) ? HRESP_OKAY : HRESP_ERROR;
            err_stall_reg <= (state_next == ERR_ERR1);
        end
    end

    assign hresp     = hresp_reg;
    assign err_stall = err_stall_reg;

endmodule

// File: tb/tb_ahb_slave_interface.sv
module tb_ahb_slave_interface;
    import ahb_apb_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic [2:0]  hsize = 3'b010;
    logic        hwrite = 1'b0;
    logic        hreadyin = 1'b1;
    logic        valid;
    logic [2:0]  tempselx;
    logic [31:0] haddr1, haddr2, haddr3, haddr4;
    logic [31:0] hwdata1, hwdata2, hwdata3, hwdata4;
    logic        hwritereg, hwritereg1, hwritereg2, hwritereg3;
    logic [1:0]  hresp;
    logic        err_stall;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ahb_slave_interface dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .htrans     (htrans),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .hreadyin   (hreadyin),
        .valid      (valid),
        .tempselx   (tempselx),
        .haddr1     (haddr1),
        .haddr2     (haddr2),
        .haddr3     (haddr3),
        .haddr4     (haddr4),
        .hwdata1    (hwdata1),
        .hwdata2    (hwdata2),
        .hwdata3    (hwdata3),
        .hwdata4    (hwdata4),
        .hwritereg  (hwritereg),
        .hwritereg1 (hwritereg1),
        .hwritereg2 (hwritereg2),
        .hwritereg3 (hwritereg3),
        .hresp      (hresp),
        .err_stall  (err_stall)
    );

    always #5 hclk = ~hclk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_bus(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr,
                           input logic wr, input logic rdy);
        haddr    = a;
        hsize    = sz;
        htrans   = tr;
        hwrite   = wr;
        hreadyin = rdy;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic        rdy;
        logic        exp_valid;
        logic [2:0]  exp_sel;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{32'h8000_0000, 3'b010, HTRANS_NONSEQ, 1'b1, 1'b1, 3'b001};
        vecs[1]  = '{32'h83FF_FFFC, 3'b010, HTRANS_SEQ,    1'b1, 1'b1, 3'b001};
        vecs[2]  = '{32'h8400_0000, 3'b010, HTRANS_NONSEQ, 1'b1, 1'b1, 3'b010};
        vecs[3]  = '{32'h87FF_FFFE, 3'b001, HTRANS_SEQ,    1'b1, 1'b1, 3'b010};
        vecs[4]  = '{32'h8800_0001, 3'b000, HTRANS_NONSEQ, 1'b1, 1'b1, 3'b100};
        vecs[5]  = '{32'h8BFF_FFFF, 3'b000, HTRANS_NONSEQ, 1'b1, 1'b1, 3'b100};
        vecs[6]  = '{32'h8C00_0000, 3'b010, HTRANS_NONSEQ, 1'b1, 1'b0, 3'b000};
        vecs[7]  = '{32'h7FFF_FFFF, 3'b000, HTRANS_NONSEQ, 1'b1, 1'b0, 3'b000};
        vecs[8]  = '{32'h8000_0001, 3'b001, HTRANS_NONSEQ, 1'b1, 1'b0, 3'b001};
        vecs[9]  = '{32'h8000_0002, 3'b010, HTRANS_NONSEQ, 1'b1, 1'b0, 3'b001};
        vecs[10] = '{32'h8000_0000, 3'b011, HTRANS_NONSEQ, 1'b1, 1'b0, 3'b001};
        vecs[11] = '{32'h8000_0000, 3'b010, HTRANS_BUSY,   1'b1, 1'b0, 3'b001};
        vecs[12] = '{32'h8000_0000, 3'b010, HTRANS_IDLE,   1'b1, 1'b0, 3'b001};
        vecs[13] = '{32'h8000_0000, 3'b010, HTRANS_NONSEQ, 1'b0, 1'b0, 3'b001};

        // ---------------- reset state ----------------
        #7;
        $display("txn reset: checking cleared state");
        chk("reset_hresp", {30'd0, hresp}, 32'd0);
        chk("reset_stall", {31'd0, err_stall}, 32'd0);
        chk("reset_haddr1", haddr1, 32'd0);
        chk("reset_haddr4", haddr4, 32'd0);
        chk("reset_hwdata1", hwdata1, 32'd0);
        chk("reset_hwritereg", {31'd0, hwritereg}, 32'd0);
        @(negedge hclk);
        hreset = 1'b0;

        // ---------------- decode table ----------------
        // Each vector is checked combinationally and retired to IDLE before the
        // next edge so the error FSM stays in OKAY throughout.
        for (int i = 0; i < 14; i++) begin
            @(negedge hclk);
            set_bus(vecs[i].addr, vecs[i].size, vecs[i].trans, 1'b0, vecs[i].rdy);
            #1;
            $display("txn vec%0d addr=%h size=%b trans=%b rdy=%b", i, vecs[i].addr,
                     vecs[i].size, vecs[i].trans, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_sel", i), {29'd0, tempselx}, {29'd0, vecs[i].exp_sel});
            #1;
            set_bus(32'h0, 3'b010, HTRANS_IDLE, 1'b0, 1'b1);
        end
        #5;
        chk("table_hresp_okay", {30'd0, hresp}, 32'd0);

        // ---------------- single write ----------------
        @(negedge hclk);
        set_bus(32'h8000_0010, 3'b010, HTRANS_NONSEQ, 1'b1, 1'b1);
        #1;
        $display("txn single write addr=80000010");
        chk("wr_valid", {31'd0, valid}, 32'd1);
        chk("wr_sel", {29'd0, tempselx}, 32'd1);
        @(posedge hclk); #1;
        chk("wr_haddr1", haddr1, 32'h8000_0010);
        chk("wr_hwritereg", {31'd0, hwritereg}, 32'd1);
        set_bus(32'h0, 3'b010, HTRANS_IDLE, 1'b0, 1'b1);
        hwdata = 32'hDEAD_BEEF;
        @(posedge hclk); #1;
        chk("wr_hwdata1", hwdata1, 32'hDEAD_BEEF);
        chk("wr_haddr2", haddr2, 32'h8000_0010);
        chk("wr_hwritereg1", {31'd0, hwritereg1}, 32'd1);

        // ---------------- burst of 4 SEQ reads ----------------
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            set_bus(32'h8400_0000 + 32'(4 * i), 3'b010, HTRANS_SEQ, 1'b0, 1'b1);
            hwdata = 32'hA000_0000 + 32'(i);
            #1;
            $display("txn burst read beat %0d addr=%h", i, haddr);
            chk($sformatf("burst%0d_valid", i), {31'd0, valid}, 32'd1);
            chk($sformatf("burst%0d_sel", i), {29'd0, tempselx}, 32'd2);
            @(posedge hclk); #1;
        end
        chk("burst_haddr4", haddr4, 32'h8400_0000);
        chk("burst_haddr3", haddr3, 32'h8400_0004);
        chk("burst_haddr2", haddr2, 32'h8400_0008);
        chk("burst_haddr1", haddr1, 32'h8400_000C);
        chk("burst_hwdata4", hwdata4, 32'hA000_0000);
        chk("burst_hwdata1", hwdata1, 32'hA000_0003);

        // ---------------- stall: hreadyin low for 3 cycles ----------------
        @(negedge hclk);
        set_bus(32'h8400_0010, 3'b010, HTRANS_SEQ, 1'b1, 1'b0);
        hwdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            $display("txn stall cycle %0d", i);
            chk($sformatf("stall%0d_valid", i), {31'd0, valid}, 32'd0);
            @(posedge hclk); #1;
            chk($sformatf("stall%0d_haddr1", i), haddr1, 32'h8400_000C);
            chk($sformatf("stall%0d_haddr4", i), haddr4, 32'h8400_0000);
            chk($sformatf("stall%0d_hwdata2", i), hwdata2, 32'hA000_0002);
            chk($sformatf("stall%0d_hwritereg", i), {31'd0, hwritereg}, 32'd0);
        end
        @(negedge hclk);
        set_bus(32'h0, 3'b010, HTRANS_IDLE, 1'b0, 1'b1);

        // ---------------- BUSY / not-ready with bad address: no error ----------------
        @(negedge hclk);
        set_bus(32'h9000_0000, 3'b010, HTRANS_BUSY, 1'b0, 1'b1);
        $display("txn busy to unmapped address");
        @(posedge hclk); #1;
        chk("busy_no_err", {30'd0, hresp}, 32'd0);
        set_bus(32'h9000_0000, 3'b010, HTRANS_NONSEQ, 1'b0, 1'b0);
        $display("txn nonseq unmapped with hreadyin low");
        @(posedge hclk); #1;
        chk("notready_no_err", {30'd0, hresp}, 32'd0);
        set_bus(32'h0, 3'b010, HTRANS_IDLE, 1'b0, 1'b1);

        // ---------------- unmapped access ----------------
        @(negedge hclk);
        set_bus(32'h9000_0000, 3'b010, HTRANS_NONSEQ, 1'b0, 1'b1);
        #1;
        $display("txn unmapped nonseq addr=90000000");
        chk("unm_valid", {31'd0, valid}, 32'd0);
        chk("unm_sel", {29'd0, tempselx}, 32'd0);
        chk("unm_hresp_pre", {30'd0, hresp}, 32'd0);
        @(posedge hclk); #1;
        chk("unm_err1_hresp", {30'd0, hresp}, 32'd1);
        chk("unm_err1_stall", {31'd0, err_stall}, 32'd1);
        set_bus(32'h0, 3'b010, HTRANS_IDLE, 1'b0, 1'b1);
        @(posedge hclk); #1;
        chk("unm_err2_hresp", {30'd0, hresp}, 32'd1);
        chk("unm_err2_stall", {31'd0, err_stall}, 32'd0);
        @(posedge hclk); #1;
        chk("unm_okay_hresp", {30'd0, hresp}, 32'd0);

        // ---------------- misaligned access, good address during ERR1 ----------------
        @(negedge hclk);
        set_bus(32'h8800_0002, 3'b010, HTRANS_NONSEQ, 1'b0, 1'b1);
        #1;
        $display("txn misaligned word addr=88000002");
        chk("mis_valid", {31'd0, valid}, 32'd0);
        chk("mis_sel", {29'd0, tempselx}, 32'd4);
        @(posedge hclk); #1;
        chk("mis_err1_hresp", {30'd0, hresp}, 32'd1);
        chk("mis_err1_stall", {31'd0, err_stall}, 32'd1);
        set_bus(32'h8800_0004, 3'b010, HTRANS_NONSEQ, 1'b0, 1'b1);
        #1;
        $display("txn good address during ERR1");
        chk("err1_good_valid", {31'd0, valid}, 32'd0);
        @(posedge hclk); #1;
        chk("mis_err2_hresp", {30'd0, hresp}, 32'd1);
        chk("mis_err2_stall", {31'd0, err_stall}, 32'd0);
        chk("err2_good_valid", {31'd0, valid}, 32'd0);
        // Bad access (size wider than word) in ERR2 restarts the error response.
        hsize = 3'b011;
        $display("txn oversize access during ERR2");
        @(posedge hclk); #1;
        chk("rerr_err1_stall", {31'd0, err_stall}, 32'd1);
        chk("rerr_err1_hresp", {30'd0, hresp}, 32'd1);
        set_bus(32'h0, 3'b010, HTRANS_IDLE, 1'b0, 1'b1);
        @(posedge hclk); #1;
        chk("rerr_err2_stall", {31'd0, err_stall}, 32'd0);
        @(posedge hclk); #1;
        chk("rerr_okay_hresp", {30'd0, hresp}, 32'd0);
        set_bus(32'h8800_0004, 3'b010, HTRANS_NONSEQ, 1'b0, 1'b1);
        #1;
        chk("post_err_valid", {31'd0, valid}, 32'd1);

        // ---------------- asynchronous reset during ERR1 ----------------
        @(negedge hclk);
        set_bus(32'h9000_0000, 3'b010, HTRANS_NONSEQ, 1'b1, 1'b1);
        hwdata = 32'h1234_5678;
        $display("txn unmapped write then reset during ERR1");
        @(posedge hclk); #1;
        chk("rst_pre_stall", {31'd0, err_stall}, 32'd1);
        chk("rst_pre_haddr1", haddr1, 32'h9000_0000);
        #1;
        hreset = 1'b1;
        #1;
        chk("rst_hresp", {30'd0, hresp}, 32'd0);
        chk("rst_stall", {31'd0, err_stall}, 32'd0);
        chk("rst_haddr1", haddr1, 32'd0);
        chk("rst_haddr2", haddr2, 32'd0);
        chk("rst_hwdata1", hwdata1, 32'd0);
        chk("rst_hwritereg", {31'd0, hwritereg}, 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        set_bus(32'h0, 3'b010, HTRANS_IDLE, 1'b0, 1'b1);
        @(posedge hclk); #1;
        chk("rst_after_hresp", {30'd0, hresp}, 32'd0);
        chk("rst_after_stall", {31'd0, err_stall}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
